// File: rtl/voice_pkg.sv
// Constants and encodings shared between the PDM sample packer and the
// recording/compare controller that consumes its packed words.
package voice_pkg;

    localparam int SAMPLE_FREQ      = 10417;
    localparam int SAMPLES_PER_WORD = 4;
    localparam int CHUNKS           = 256;

    typedef enum logic [1:0] {
        DIR_IDLE    = 2'd0,
        DIR_RECORD  = 2'd1,
        DIR_COMPARE = 2'd2
    } dir_e;

endpackage

// File: rtl/pdm_clk_gen.sv
// Divides clk down to the PDM microphone clock and flags the cycle in which
// the registered mic clock has just fallen, when mic data is stable.
module pdm_clk_gen #(
    parameter int HALF_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    output logic mic_clk,
    output logic tick
);

    localparam int DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic             mic_clk_reg;
    logic             tick_reg;
    logic             wrap;

    assign wrap = (div_reg == DIV_W'(HALF_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg     <= '0;
            mic_clk_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            div_reg <= wrap ? '0 : div_reg + DIV_W'(1);
            if (wrap) begin
                mic_clk_reg <= ~mic_clk_reg;
            end
            // Raised together with the 1->0 transition of the registered clock.
            tick_reg <= wrap && mic_clk_reg;
        end
    end

    assign mic_clk = mic_clk_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/pdm_sample_packer.sv
// PDM front end: counts ones per window of mic clocks into a saturating
// sample and packs four samples per word, announced with a one-cycle ram_wr.
module pdm_sample_packer
    import voice_pkg::*;
#(
    parameter int HALF_DIV = 20,
    parameter int WINDOW   = 240,
    parameter int COUNT_W  = 8,
    parameter int SAMPLE_W = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               count_en,
    input  logic                               micData,
    output logic                               micClk,
    output logic                               micLRSel,
    output logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] ram_data,
    output logic                               ram_wr
);

    localparam int SLOT_W = $clog2(SAMPLES_PER_WORD);
    localparam int WORD_W = SAMPLES_PER_WORD * SAMPLE_W;
    localparam logic [31:0] SAMPLE_MAX = 32'((64'd1 << SAMPLE_W) - 64'd1);

    logic              tick;
    logic              sync1_reg;
    logic              mic_s;
    logic [COUNT_W-1:0] ones_reg;
    logic [COUNT_W-1:0] win_reg;
    logic [SLOT_W-1:0]  slot_reg;
    logic [WORD_W-1:0]  ram_data_reg;
    logic               ram_wr_reg;
    logic [SAMPLE_W-1:0] pack_reg [SAMPLES_PER_WORD-1];
    logic [WORD_W-1:0]  word_full;
    logic [31:0]        sum;
    logic [SAMPLE_W-1:0] sample;
    logic               last_bit;
    logic               take;

    pdm_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .mic_clk (micClk),
        .tick    (tick)
    );

    assign micLRSel = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            mic_s     <= 1'b0;
        end else begin
            sync1_reg <= micData;
            mic_s     <= sync1_reg;
        end
    end

    // The closing bit is folded into the sample before saturating.
    assign sum      = 32'(ones_reg) + 32'(mic_s);
    assign sample   = (sum > SAMPLE_MAX) ? SAMPLE_W'(SAMPLE_MAX) : SAMPLE_W'(sum);
    assign last_bit = (win_reg == COUNT_W'(WINDOW - 1));
    assign take     = tick && count_en;

    genvar gi;
    generate
        for (gi = 0; gi < SAMPLES_PER_WORD - 1; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pack_reg[gi] <= '0;
                end else if (!count_en) begin
                    pack_reg[gi] <= '0;
                end else if (take && last_bit && slot_reg == SLOT_W'(gi)) begin
                    pack_reg[gi] <= sample;
                end
            end
            assign word_full[gi*SAMPLE_W +: SAMPLE_W] = pack_reg[gi];
        end
    endgenerate

    // The top slot comes straight from the sample being closed.
    assign word_full[WORD_W-1 -: SAMPLE_W] = sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_reg     <= '0;
            win_reg      <= '0;
            slot_reg     <= '0;
            ram_data_reg <= '0;
            ram_wr_reg   <= 1'b0;
        end else begin
            ram_wr_reg <= 1'b0;
            if (!count_en) begin
                ones_reg <= '0;
                win_reg  <= '0;
                slot_reg <= '0;
            end else if (tick) begin
                if (last_bit) begin
                    ones_reg <= '0;
                    win_reg  <= '0;
                    slot_reg <= slot_reg + SLOT_W'(1);
                    if (slot_reg == SLOT_W'(SAMPLES_PER_WORD - 1)) begin
                        ram_data_reg <= word_full;
                        ram_wr_reg   <= 1'b1;
                    end
                end else begin
                    ones_reg <= ones_reg + COUNT_W'(mic_s);
                    win_reg  <= win_reg + COUNT_W'(1);
                end
            end
        end
    end

    assign ram_data = ram_data_reg;
    assign ram_wr   = ram_wr_reg;

endmodule

// File: tb/tb_pdm_sample_packer.sv
// Randomised and directed checks of pdm_sample_packer against a cycle-counting
// behavioural model, plus a saturating instance with a long window.
module tb_pdm_sample_packer;

    localparam int H = 2;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_sat = 1'b1;
    logic        count_en = 1'b0;
    logic        mic_data = 1'b0;
    logic        sat_en = 1'b1;
    logic        sat_mic = 1'b1;
    logic        mic_clk, mic_lr, ram_wr;
    logic [31:0] ram_data;
    logic        sat_clk, sat_lr, sat_wr;
    logic [31:0] sat_data;

    int total = 0;
    int bad = 0;
    int mode = 1;

    always #5 clk = ~clk;

    pdm_sample_packer #(.HALF_DIV(H), .WINDOW(W), .COUNT_W(8), .SAMPLE_W(8)) dut (
        .clk(clk), .rst(rst), .count_en(count_en), .micData(mic_data),
        .micClk(mic_clk), .micLRSel(mic_lr), .ram_data(ram_data), .ram_wr(ram_wr)
    );

    pdm_sample_packer #(.HALF_DIV(H), .WINDOW(300), .COUNT_W(9), .SAMPLE_W(8)) dut_sat (
        .clk(clk), .rst(rst_sat), .count_en(sat_en), .micData(sat_mic),
        .micClk(sat_clk), .micLRSel(sat_lr), .ram_data(sat_data), .ram_wr(sat_wr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Behavioural model: edges counted since reset release; the mic clock
    // falls every 2*H edges, and the bit counted at an edge is the one
    // presented two edges before it.
    int          e = 0;
    int          m_ones = 0, m_win = 0, m_slot = 0;
    int          m_samp [4];
    logic [31:0] m_data = '0;
    logic        m_wr = 1'b0;
    logic        d1 = 1'b0, d2 = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e = 0; m_ones = 0; m_win = 0; m_slot = 0;
                m_data = '0; m_wr = 1'b0; d1 = 1'b0; d2 = 1'b0;
            end else begin
                e++;
                m_wr = 1'b0;
                if (!count_en) begin
                    m_ones = 0; m_win = 0; m_slot = 0;
                end else if ((e - 1) > 0 && ((e - 1) % (2 * H)) == 0) begin
                    m_ones += int'(d2);
                    m_win++;
                    if (m_win == W) begin
                        m_samp[m_slot] = (m_ones > 255) ? 255 : m_ones;
                        if (m_slot == 3) begin
                            m_data = {m_samp[3][7:0], m_samp[2][7:0], m_samp[1][7:0], m_samp[0][7:0]};
                            m_wr = 1'b1;
                        end
                        m_ones = 0; m_win = 0;
                        m_slot = (m_slot + 1) % 4;
                    end
                end
                d2 = d1;
                d1 = mic_data;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("micclk", 32'(mic_clk), 32'((e / H) % 2));
            chk("lrsel", 32'(mic_lr), 32'(0));
            chk("ram_wr", 32'(ram_wr), 32'(m_wr));
            chk("ram_data", ram_data, m_data);
        end
    end

    // Mic data driver.
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0: mic_data = 1'b0;
                1: mic_data = 1'b1;
                2: if (e % (2 * H) == 0) mic_data = ~mic_data;
                default: mic_data = 1'($urandom);
            endcase
        end
    end

    // Saturating instance monitor.
    int sat_e = 0;
    int sat_n = 0;
    int sat_t [2];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_sat) sat_e++;
            if (sat_wr) begin
                chk("sat_word", sat_data, 32'hFFFF_FFFF);
                if (sat_n < 2) sat_t[sat_n] = sat_e;
                sat_n++;
                $display("sat word %h at edge %0d", sat_data, sat_e);
            end
        end
    end

    task automatic wait_wr(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ram_wr && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ram_wr) begin
            total++;
            bad++;
            $display("FAIL %s actual=no_ram_wr required=ram_wr_within_400", name);
        end else begin
            $display("word %h at edge %0d (%s)", ram_data, e, name);
        end
    endtask

    initial begin
        int n;
        int e0;
        int last;
        int wrs;

        mode = 1;
        count_en = 1'b1;
        rst = 1'b1;
        rst_sat = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        rst_sat = 1'b0;

        // Clock generation: first rise two cycles after release, period 4.
        @(negedge clk); chk("micclk_e1", 32'(mic_clk), 32'(0));
        @(negedge clk); chk("micclk_e2", 32'(mic_clk), 32'(1));
        @(negedge clk); chk("micclk_e3", 32'(mic_clk), 32'(1));
        @(negedge clk); chk("micclk_e4", 32'(mic_clk), 32'(0));

        // Constant ones.
        wait_wr("ones0");
        chk("first_word_edge", 32'(e), 32'(129));
        chk("ones_word0", ram_data, 32'h0808_0808);
        for (int i = 1; i < 3; i++) begin
            last = e;
            wait_wr("ones");
            chk("ones_interval", 32'(e - last), 32'(128));
            chk("ones_word", ram_data, 32'h0808_0808);
        end

        // Alternating, then zeros.
        mode = 2;
        wait_wr("alt_skip");
        for (int i = 0; i < 2; i++) begin
            wait_wr("alt");
            chk("alt_word", ram_data, 32'h0404_0404);
        end
        mode = 0;
        wait_wr("zero_skip");
        wait_wr("zero");
        chk("zero_word", ram_data, 32'h0000_0000);

        // count_en dropped after two samples.
        mode = 3;
        n = 0;
        while (m_slot != 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_slot2", 32'(m_slot), 32'(2));
        count_en = 1'b0;
        wrs = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wr) wrs++;
        end
        chk("no_wr_while_low", 32'(wrs), 32'(0));
        count_en = 1'b1;
        e0 = e;
        wait_wr("reenable");
        chk("reenable_latency", 32'((e - e0) >= 125 && (e - e0) <= 128), 32'(1));

        // Random data with occasional count_en drops.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            count_en = ($urandom_range(0, 199) != 0);
        end

        // Asynchronous reset mid-window.
        count_en = 1'b1;
        mode = 1;
        wait_wr("pre_reset");
        chk("pre_reset_word", ram_data, 32'h0808_0808);
        n = 0;
        while (m_win != 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", ram_data, 32'h0);
        chk("async_rst_wr", 32'(ram_wr), 32'(0));
        chk("async_rst_micclk", 32'(mic_clk), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_wr("post_reset");
        chk("post_reset_edge", 32'(e), 32'(129));
        chk("post_reset_word", ram_data, 32'h0808_0808);

        // Saturating instance: two words.
        n = 0;
        while (sat_n < 2 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_words_seen", 32'(sat_n >= 2), 32'(1));
        if (sat_n >= 2) begin
            chk("sat_first_edge", 32'(sat_t[0]), 32'(4801));
            chk("sat_interval", 32'(sat_t[1] - sat_t[0]), 32'(4800));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
